// File: rtl/sobel_window_gen.sv
// sobel_window_gen: two-line-buffer 3x3 window generator feeding the Sobel stage.
// Emits WIDTH*HEIGHT raster-ordered windows per frame; border centers carry zero taps.
module sobel_window_gen #(
    parameter int WIDTH = 768,
    parameter int HEIGHT = 512,
    parameter int BITS_FOR_INDEX = 10,
    parameter int sizeOfWidth = 8
) (
    input  logic                      CAMERA_CLK,
    input  logic                      rst,
    input  logic                      pix_valid,
    input  logic                      pix_sof,
    input  logic [sizeOfWidth-1:0]    pix_data,
    output logic                      in_ready,
    output logic [sizeOfWidth-1:0]    ul,
    output logic [sizeOfWidth-1:0]    uc,
    output logic [sizeOfWidth-1:0]    ur,
    output logic [sizeOfWidth-1:0]    ml,
    output logic [sizeOfWidth-1:0]    mc,
    output logic [sizeOfWidth-1:0]    mr,
    output logic [sizeOfWidth-1:0]    dl,
    output logic [sizeOfWidth-1:0]    dc,
    output logic [sizeOfWidth-1:0]    dr,
    output logic [BITS_FOR_INDEX-1:0] rowIndex,
    output logic [BITS_FOR_INDEX-1:0] colIndex,
    output logic                      readWrite,
    output logic                      frame_done
);
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BITS_FOR_INDEX-1:0] W_LAST = BITS_FOR_INDEX'(WIDTH - 1);
    localparam logic [BITS_FOR_INDEX-1:0] H_LAST = BITS_FOR_INDEX'(HEIGHT - 1);
    localparam logic [BITS_FOR_INDEX-1:0] ONE = BITS_FOR_INDEX'(1);

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

    state_t                    state;
    logic [BITS_FOR_INDEX-1:0] in_row, in_col, out_row, out_col;
    logic [sizeOfWidth-1:0]    lb0 [WIDTH];
    logic [sizeOfWidth-1:0]    lb1 [WIDTH];
    logic [sizeOfWidth-1:0]    a_u, a_m, a_d, b_u, b_m, b_d;
    logic [sizeOfWidth-1:0]    up, mid;
    logic [AW-1:0]             col;
    logic                      accept, resync, emit, border, in_last, out_last;

    assign in_ready = (state != FLUSH);
    assign accept   = pix_valid & in_ready;
    assign resync   = accept & pix_sof;
    assign col      = resync ? '0 : in_col[AW-1:0];
    assign up       = lb1[col];
    assign mid      = lb0[col];
    assign in_last  = (in_row == H_LAST) && (in_col == W_LAST);
    assign out_last = (out_row == H_LAST) && (out_col == W_LAST);
    assign border   = (out_row == '0) || (out_row == H_LAST) || (out_col == '0) || (out_col == W_LAST);
    assign emit     = (state == FLUSH) ||
                      (accept && !resync && (state == STREAM || (in_row == ONE && in_col == ONE)));

    always_ff @(posedge CAMERA_CLK) begin
        if (accept) begin
            lb1[col] <= mid;
            lb0[col] <= pix_data;
        end
    end

    // a_* / b_* keep the two previous raw columns so interior windows see true
    // neighbours even when the preceding window was a zeroed border.
    always_ff @(posedge CAMERA_CLK or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            in_row     <= '0;
            in_col     <= '0;
            out_row    <= '0;
            out_col    <= '0;
            a_u        <= '0;
            a_m        <= '0;
            a_d        <= '0;
            b_u        <= '0;
            b_m        <= '0;
            b_d        <= '0;
            ul         <= '0;
            uc         <= '0;
            ur         <= '0;
            ml         <= '0;
            mc         <= '0;
            mr         <= '0;
            dl         <= '0;
            dc         <= '0;
            dr         <= '0;
            rowIndex   <= '0;
            colIndex   <= '0;
            readWrite  <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            readWrite  <= !emit;
            frame_done <= emit && out_last;
            if (accept) begin
                a_u <= b_u;
                a_m <= b_m;
                a_d <= b_d;
                b_u <= up;
                b_m <= mid;
                b_d <= pix_data;
            end
            if (emit) begin
                ul       <= border ? '0 : a_u;
                uc       <= border ? '0 : b_u;
                ur       <= border ? '0 : up;
                ml       <= border ? '0 : a_m;
                mc       <= border ? '0 : b_m;
                mr       <= border ? '0 : mid;
                dl       <= border ? '0 : a_d;
                dc       <= border ? '0 : b_d;
                dr       <= border ? '0 : pix_data;
                rowIndex <= out_row;
                colIndex <= out_col;
            end
            if (resync) begin
                in_row  <= '0;
                in_col  <= ONE;
                out_row <= '0;
                out_col <= '0;
                state   <= FILL;
            end else begin
                if (accept) begin
                    in_col <= (in_col == W_LAST) ? '0 : in_col + ONE;
                    if (in_col == W_LAST)
                        in_row <= (in_row == H_LAST) ? '0 : in_row + ONE;
                end
                if (emit) begin
                    out_col <= (out_col == W_LAST) ? '0 : out_col + ONE;
                    if (out_col == W_LAST)
                        out_row <= (out_row == H_LAST) ? '0 : out_row + ONE;
                end
                state <= (state == FILL && emit) ? STREAM :
                         (state == STREAM && accept && in_last) ? FLUSH :
                         (state == FLUSH && out_last) ? FILL : state;
            end
        end
    end
endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Upstream neighbour of the Sobel edge stage. Accepts an 8-bit grayscale pixel stream in raster order, holds two previous image rows in internal line buffers, and emits one registered 3x3 neighbourhood plus center coordinates per image pixel. The output port set plugs directly into the Sobel stage's `ul`..`dr`, `rowIndex`, `colIndex` and `readWrite` inputs. A flush phase guarantees exactly WIDTH*HEIGHT windows per frame.

## Interface
- `WIDTH`, 768: image width in pixels.
- `HEIGHT`, 512: image height in pixels.
- `BITS_FOR_INDEX`, 10: coordinate width, ceil(lg(max(WIDTH,HEIGHT))).
- `sizeOfWidth`, 8: pixel width.
- `CAMERA_CLK` in 1: sole clock; everything on its rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `pix_valid` in 1: input pixel present this cycle.
- `pix_sof` in 1: qualified by `pix_valid`; marks pixel (0,0) of a frame.
- `pix_data` in sizeOfWidth: input pixel.
- `in_ready` out 1: pixel accepted when `pix_valid & in_ready`.
- `ul`,`uc`,`ur`,`ml`,`mc`,`mr`,`dl`,`dc`,`dr` out sizeOfWidth each: window taps, u/m/d = rows y-1/y/y+1, l/c/r = cols x-1/x/x+1.
- `rowIndex` out BITS_FOR_INDEX: center row y.
- `colIndex` out BITS_FOR_INDEX: center column x.
- `readWrite` out 1: active-low window valid; 0 for exactly one cycle per emitted window.
- `frame_done` out 1: one-cycle pulse coincident with the last window of a frame (center HEIGHT-1, WIDTH-1).

## Operation
- Storage: two line buffers `lb0` (row r-1) and `lb1` (row r-2), WIDTH entries each, combinational read. There is also a 3x3 tap register array. Line buffers are not cleared at reset.
- On accept of pixel p at input (r,c):
  - read `lb1[c]` and `lb0[c]`;
  - write `lb1[c]<=lb0[c]` and `lb0[c]<=p`;
  - shift the taps left one column;
  - load the new right column `ur=lb1[c]`, `mr=lb0[c]`, `dr=p`.
- The resulting window is centered at (r-1, c-1). Equivalently, linear center index = input index - (WIDTH+1).
- Input counters `in_row`/`in_col` advance raster-wise per accept. `in_col` wraps at WIDTH-1 and `in_row` increments. Output counters `out_row`/`out_col` advance per emitted window.
- Border centers (y==0, x==0, y==HEIGHT-1, x==WIDTH-1) are emitted with all nine taps forced to 0. Interior windows carry true neighbours.
- FSM states:
  - FILL: entered at reset and after each frame. Accepts pixels and emits nothing while input index < WIDTH+1. When input index WIDTH+1 is reached, goes to STREAM, and that accept emits center (0,0).
  - STREAM: each accept emits one window. Accepting the last pixel (HEIGHT-1, WIDTH-1) goes to FLUSH.
  - FLUSH: `in_ready`=0. Emits the remaining WIDTH+1 border centers, one per cycle, with no input needed. The last one, (HEIGHT-1, WIDTH-1), pulses `frame_done`, then returns to FILL with all counters at 0.
- `pix_sof` on an accepted pixel outside FILL index 0 resynchronises. Counters restart with that pixel as (0,0), the state becomes FILL, and any pending flush is abandoned with no `frame_done`.
- `pix_sof` is ignored in FLUSH because `in_ready`=0 and nothing is accepted.
- A pixel without `pix_sof` at index 0 is accepted as (0,0).
- There is no output backpressure. The consumer takes one window per cycle.
- `in_ready` = (state != FLUSH), combinational.

## Timing
- Reset values:
  - taps and coordinates = 0;
  - `readWrite`=1, `frame_done`=0;
  - state FILL, counters 0, so `in_ready`=1 during and after reset.
- Latency: a window is registered on the edge that accepts its right-column pixel. Outputs are visible one cycle after the accepting `pix_valid` cycle.
- Idle input cycles (`pix_valid`=0) in FILL/STREAM: `readWrite`=1, taps hold.
- FLUSH lasts exactly WIDTH+1 cycles, with `readWrite`=0 on each.
- Asynchronous reset mid-frame: outputs go to reset values immediately. The next accepted pixel is (0,0).
- Per frame: exactly WIDTH*HEIGHT windows with `readWrite`=0, in strict raster order of (rowIndex, colIndex).

## Test plan
All tests use WIDTH=8, HEIGHT=6.
- Reset: hold `rst`=0 for 3 cycles, then release → `readWrite`=1, taps 0, `in_ready`=1, `frame_done`=0.
- Ramp frame: `pix_data`=r*8+c, continuous valid → first window one cycle after the 10th accept at center (0,0) with taps 0. Center (1,1) is `ul`=0, `uc`=1, `ur`=2, `ml`=8, `mc`=9, `mr`=10, `dl`=16, `dc`=17, `dr`=18. 48 windows total, `frame_done` on (5,7).
- Flush: after the 48th accept → `in_ready`=0 for 9 cycles, centers (4,7) and (5,0)..(5,7) emitted, all taps 0.
- Gaps: random `pix_valid` deassertion on the ramp frame → identical window sequence, with `readWrite`=1 in gap cycles.
- Resync: `pix_sof` at frame pixel 20 → counters restart. No `frame_done` until 48 more pixels have been accepted.
- Mid-frame reset: assert `rst` during STREAM, then send a full frame → correct 48-window sequence, one `frame_done`.
